cam_frame_writer: RTL and testbench

- Downstream of the camera capture stage, in the pclk domain.
- Consumes the capture stage's pixel stream (data12, addr_wr, buff_wr) plus vsync, and drives the write port of a ping-pong (two-bank) frame buffer BRAM.
- Locks the write bank at each frame start to the bank the display is not reading, validates frame length, and publishes the last complete bank to the display side.

---
 rtl/cam_frame_writer_if.sv | 12 +
 rtl/cam_frame_writer.sv | 145 ++++++++++++++
 tb/tb_cam_frame_writer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_frame_writer_if.sv
// Pixel stream from the capture stage into the frame writer.
interface cam_frame_writer_if #(
    parameter int unsigned AW = 17
) ();
    logic          vsync;
    logic          buff_wr;
    logic [AW-1:0] addr_wr;
    logic [11:0]   data12;

    modport master (output vsync, output buff_wr, output addr_wr, output data12);
    modport slave  (input  vsync, input  buff_wr, input  addr_wr, input  data12);
endinterface

// File: rtl/cam_frame_writer.sv
// Writes camera frames into a ping-pong frame buffer, validates frame length and
// publishes the last complete bank to the display side.
module cam_frame_writer #(
    parameter int unsigned FRAME_PIXELS = 76800,
    parameter int unsigned AW           = 17,
    parameter int unsigned CW           = 16
) (
    input  logic                pclk,
    input  logic                rst,
    cam_frame_writer_if.slave   pix,
    input  logic                rd_bank,
    output logic                bram_we,
    output logic [AW:0]         bram_addr,
    output logic [11:0]         bram_din,
    output logic                wr_bank,
    output logic                done_bank,
    output logic                done_valid,
    output logic                frame_done,
    output logic                frame_err,
    output logic [CW-1:0]       frame_count
);
    localparam logic [AW-1:0] FrameLen = AW'(FRAME_PIXELS);

    typedef enum logic [1:0] {StWaitLow, StWaitHigh, StCapture} state_e;

    state_e          state_q, state_d;
    logic            rd_meta_q, rd_s_q, vs_q;
    logic [AW-1:0]   pix_cnt_q, pix_cnt_d;
    logic            ovf_q, ovf_d;
    logic            bram_we_q, bram_we_d;
    logic [AW:0]     bram_addr_q, bram_addr_d;
    logic [11:0]     bram_din_q, bram_din_d;
    logic            wr_bank_q, wr_bank_d;
    logic            done_bank_q, done_bank_d;
    logic            done_valid_q, done_valid_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_err_q, frame_err_d;
    logic [CW-1:0]   frame_count_q, frame_count_d;

    logic rise, fall, strobe, addr_ok, addr_hi, frame_good;

    assign rise       = pix.vsync & ~vs_q;
    assign fall       = ~pix.vsync & vs_q;
    assign strobe     = (state_q == StCapture) & pix.buff_wr & pix.vsync;
    assign addr_ok    = (pix.addr_wr != '0) && (pix.addr_wr <= FrameLen);
    assign addr_hi    = pix.addr_wr > FrameLen;
    assign frame_good = (pix_cnt_q == FrameLen) && !ovf_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q       <= StWaitLow;
            rd_meta_q     <= 1'b0;
            rd_s_q        <= 1'b0;
            vs_q          <= 1'b0;
            pix_cnt_q     <= '0;
            ovf_q         <= 1'b0;
            bram_we_q     <= 1'b0;
            bram_addr_q   <= '0;
            bram_din_q    <= '0;
            wr_bank_q     <= 1'b0;
            done_bank_q   <= 1'b0;
            done_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            rd_meta_q     <= rd_bank;
            rd_s_q        <= rd_meta_q;
            vs_q          <= pix.vsync;
            pix_cnt_q     <= pix_cnt_d;
            ovf_q         <= ovf_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_din_q    <= bram_din_d;
            wr_bank_q     <= wr_bank_d;
            done_bank_q   <= done_bank_d;
            done_valid_q  <= done_valid_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Waiting for vsync low first drops any frame already in flight at reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StWaitLow:  if (!pix.vsync) state_d = StWaitHigh;
            StWaitHigh: if (rise)       state_d = StCapture;
            StCapture:  if (fall)       state_d = StWaitHigh;
            default:                    state_d = StWaitLow;
        endcase
    end

    always_comb begin
        pix_cnt_d     = pix_cnt_q;
        ovf_d         = ovf_q;
        bram_we_d     = 1'b0;
        bram_addr_d   = bram_addr_q;
        bram_din_d    = bram_din_q;
        wr_bank_d     = wr_bank_q;
        done_bank_d   = done_bank_q;
        done_valid_d  = done_valid_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;

        // Lock onto the bank the display is not reading for the whole frame.
        if (state_q == StWaitHigh && rise) begin
            wr_bank_d = ~rd_s_q;
            pix_cnt_d = '0;
            ovf_d     = 1'b0;
        end

        if (strobe && addr_ok) begin
            bram_we_d   = 1'b1;
            bram_addr_d = {wr_bank_q, pix.addr_wr - AW'(1)};
            bram_din_d  = pix.data12;
            if (pix_cnt_q != '1) pix_cnt_d = pix_cnt_q + AW'(1);
        end
        if (strobe && addr_hi) ovf_d = 1'b1;

        if (state_q == StCapture && fall) begin
            if (frame_good) begin
                frame_done_d  = 1'b1;
                done_bank_d   = wr_bank_q;
                done_valid_d  = 1'b1;
                frame_count_d = frame_count_q + CW'(1);
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_din    = bram_din_q;
    assign wr_bank     = wr_bank_q;
    assign done_bank   = done_bank_q;
    assign done_valid  = done_valid_q;
    assign frame_done  = frame_done_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;
endmodule

// File: tb/tb_cam_frame_writer.sv
// Bench for cam_frame_writer: reduced frame size, reference model, vector table,
// hand sequences and a small-counter instance for wrap-around.
module tb_cam_frame_writer;
    localparam int FP  = 16;
    localparam int AW  = 5;
    localparam int FP2 = 4;
    localparam int AW2 = 3;

    logic pclk = 1'b0;
    logic rst;
    logic rd_bank;

    always #5 pclk = ~pclk;

    cam_frame_writer_if #(.AW(AW))  pix ();
    cam_frame_writer_if #(.AW(AW2)) pix2 ();

    logic          bram_we, wr_bank, done_bank, done_valid, frame_done, frame_err;
    logic [AW:0]   bram_addr;
    logic [11:0]   bram_din;
    logic [15:0]   frame_count;

    logic          bram_we2, wr_bank2, done_bank2, done_valid2, frame_done2, frame_err2;
    logic [AW2:0]  bram_addr2;
    logic [11:0]   bram_din2;
    logic [3:0]    frame_count2;

    cam_frame_writer #(.FRAME_PIXELS(FP), .AW(AW), .CW(16)) dut (
        .pclk(pclk), .rst(rst), .pix(pix), .rd_bank(rd_bank),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .wr_bank(wr_bank), .done_bank(done_bank), .done_valid(done_valid),
        .frame_done(frame_done), .frame_err(frame_err), .frame_count(frame_count)
    );

    cam_frame_writer #(.FRAME_PIXELS(FP2), .AW(AW2), .CW(4)) dut_wrap (
        .pclk(pclk), .rst(rst), .pix(pix2), .rd_bank(1'b0),
        .bram_we(bram_we2), .bram_addr(bram_addr2), .bram_din(bram_din2),
        .wr_bank(wr_bank2), .done_bank(done_bank2), .done_valid(done_valid2),
        .frame_done(frame_done2), .frame_err(frame_err2), .frame_count(frame_count2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: frame-level view (armed, in a frame, accepted pixels, overrun seen).
    bit        m_armed, m_active, m_bad, m_bank, m_prev_vs, rd_h1, rd_h2;
    int        m_cnt;
    bit        e_we, e_done, e_err, e_dbank, e_dvalid;
    int        e_addr, e_din;
    int        e_count;

    task automatic model_edge(input bit r, input bit vs, input bit bw, input int a,
                              input int d, input bit rd);
        bit rd_seen;
        if (r) begin
            m_armed = 0; m_active = 0; m_bad = 0; m_bank = 0; m_prev_vs = 0;
            rd_h1 = 0; rd_h2 = 0; m_cnt = 0;
            e_we = 0; e_done = 0; e_err = 0; e_dbank = 0; e_dvalid = 0;
            e_addr = 0; e_din = 0; e_count = 0;
            return;
        end
        rd_seen = rd_h2;
        e_we = 0; e_done = 0; e_err = 0;
        if (!m_armed) begin
            if (!vs) m_armed = 1;
        end else if (!m_active) begin
            if (vs && !m_prev_vs) begin
                m_active = 1; m_bank = !rd_seen; m_cnt = 0; m_bad = 0;
            end
        end else if (!vs && m_prev_vs) begin
            m_active = 0;
            if (m_cnt == FP && !m_bad) begin
                e_done = 1; e_dbank = m_bank; e_dvalid = 1;
                e_count = (e_count + 1) % 65536;
            end else begin
                e_err = 1;
            end
        end else if (bw && vs) begin
            if (a >= 1 && a <= FP) begin
                e_we = 1; e_addr = (int'(m_bank) << AW) + a - 1; e_din = d; m_cnt++;
            end else if (a > FP) begin
                m_bad = 1;
            end
        end
        m_prev_vs = vs;
        rd_h2 = rd_h1;
        rd_h1 = rd;
    endtask

    int we_pulses, first_addr, last_addr, done_pulses, err_pulses;

    task automatic clear_stats();
        we_pulses = 0; first_addr = -1; last_addr = -1; done_pulses = 0; err_pulses = 0;
    endtask

    task automatic cyc(input bit vs, input bit bw, input int a, input int d);
        logic [31:0] av;
        av = a;
        pix.vsync   = vs;
        pix.buff_wr = bw;
        pix.addr_wr = av[AW-1:0];
        pix.data12  = d[11:0];
        @(posedge pclk);
        model_edge(rst, vs, bw, a, d & 32'hFFF, rd_bank);
        #1;
        chk("bram_we", bram_we, e_we);
        chk("bram_addr", bram_addr, e_addr);
        chk("bram_din", bram_din, e_din);
        chk("wr_bank", wr_bank, m_bank);
        chk("done_bank", done_bank, e_dbank);
        chk("done_valid", done_valid, e_dvalid);
        chk("frame_done", frame_done, e_done);
        chk("frame_err", frame_err, e_err);
        chk("frame_count", frame_count, e_count);
        if (bram_we) begin
            if (we_pulses == 0) first_addr = bram_addr;
            last_addr = bram_addr;
            we_pulses++;
        end
        if (frame_done) done_pulses++;
        if (frame_err) err_pulses++;
    endtask

    // One frame: rise, addresses first..last (one strobe every gap cycles), fall.
    task automatic frame(input int first_a, input int last_a, input int gap, input int flip_at);
        cyc(1, 0, 0, 0);
        for (int a = first_a; a <= last_a; a++) begin
            if (a == flip_at) rd_bank = ~rd_bank;
            for (int g = 1; g < gap; g++) cyc(1, 0, 0, 0);
            cyc(1, 1, a, $urandom);
        end
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    task automatic cyc2(input bit vs, input bit bw, input int a);
        logic [31:0] av;
        av = a;
        pix2.vsync   = vs;
        pix2.buff_wr = bw;
        pix2.addr_wr = av[AW2-1:0];
        pix2.data12  = 12'h5A5;
        @(posedge pclk);
        #1;
        if (frame_done2) done_pulses++;
    endtask

    typedef struct {
        bit bw;
        int addr;
        bit exp_we;
        int exp_addr;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{bw: 1, addr: 1,  exp_we: 1, exp_addr: 'h20};
        vecs[1] = '{bw: 1, addr: 16, exp_we: 1, exp_addr: 'h2F};
        vecs[2] = '{bw: 1, addr: 0,  exp_we: 0, exp_addr: 'h2F};
        vecs[3] = '{bw: 1, addr: 17, exp_we: 0, exp_addr: 'h2F};
        vecs[4] = '{bw: 0, addr: 5,  exp_we: 0, exp_addr: 'h2F};
        vecs[5] = '{bw: 1, addr: 31, exp_we: 0, exp_addr: 'h2F};
        vecs[6] = '{bw: 1, addr: 8,  exp_we: 1, exp_addr: 'h27};

        rst = 1'b1;
        rd_bank = 1'b0;
        pix.vsync = 0; pix.buff_wr = 0; pix.addr_wr = '0; pix.data12 = '0;
        pix2.vsync = 0; pix2.buff_wr = 0; pix2.addr_wr = '0; pix2.data12 = '0;

        // Reset with vsync high: the frame already in progress must be discarded.
        cyc(1, 1, 3, 0);
        cyc(1, 1, 4, 0);
        chk("reset_count", frame_count, 0);
        chk("reset_we", bram_we, 0);
        rst = 1'b0;
        clear_stats();
        for (int i = 0; i < 3; i++) cyc(1, 1, 5 + i, i);
        chk("no_write_before_low", we_pulses, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);

        // Full frame, strobe every 4th cycle.
        clear_stats();
        frame(1, FP, 4, -1);
        chk("full_wr_bank", wr_bank, 1);
        chk("full_we_pulses", we_pulses, FP);
        chk("full_first_addr", first_addr, 'h20);
        chk("full_last_addr", last_addr, 'h2F);
        chk("full_done_pulses", done_pulses, 1);
        chk("full_done_bank", done_bank, 1);
        chk("full_done_valid", done_valid, 1);
        chk("full_count", frame_count, 1);

        // Short frame.
        clear_stats();
        frame(1, FP - 1, 1, -1);
        chk("short_err", err_pulses, 1);
        chk("short_done", done_pulses, 0);
        chk("short_count", frame_count, 1);
        chk("short_done_bank", done_bank, 1);

        // Long frame: last address is out of range.
        clear_stats();
        frame(1, FP + 1, 1, -1);
        chk("long_we_pulses", we_pulses, FP);
        chk("long_err", err_pulses, 1);
        chk("long_count", frame_count, 1);

        // Address classification vectors inside one frame.
        clear_stats();
        cyc(1, 0, 0, 0);
        foreach (vecs[i]) begin
            cyc(1, vecs[i].bw, vecs[i].addr, 'hA00 + i);
            chk("tbl_we", bram_we, vecs[i].exp_we);
            chk("tbl_addr", bram_addr, vecs[i].exp_addr);
            if (vecs[i].exp_we) chk("tbl_din", bram_din, 'hA00 + i);
        end
        cyc(0, 0, 0, 0);
        chk("tbl_frame_err", frame_err, 1);
        cyc(0, 0, 0, 0);

        // rd_bank flips mid-frame: current frame keeps its bank, next one switches.
        clear_stats();
        frame(1, FP, 1, 6);
        chk("flip_wr_bank_held", wr_bank, 1);
        chk("flip_done_bank", done_bank, 1);
        frame(1, FP, 1, -1);
        chk("flip_next_wr_bank", wr_bank, 0);
        chk("flip_next_done_bank", done_bank, 0);
        chk("flip_count", frame_count, 3);

        // Reset in the middle of a frame, released with vsync still high.
        rd_bank = 1'b0;
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        for (int a = 1; a <= FP / 2; a++) cyc(1, 1, a, a);
        rst = 1'b1;
        cyc(1, 1, FP / 2 + 1, 0);
        rst = 1'b0;
        chk("midrst_count", frame_count, 0);
        chk("midrst_valid", done_valid, 0);
        clear_stats();
        for (int a = FP / 2 + 2; a <= FP; a++) cyc(1, 1, a, a);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("midrst_no_writes", we_pulses, 0);
        chk("midrst_no_err", err_pulses, 0);
        chk("midrst_no_done", done_pulses, 0);
        frame(1, FP, 2, -1);
        chk("midrst_after_done", done_pulses, 1);
        chk("midrst_after_count", frame_count, 1);

        // Randomised frames against the model.
        for (int f = 0; f < 40; f++) begin
            int kind, gap;
            kind = $urandom_range(0, 3);
            gap  = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) rd_bank = ~rd_bank;
            cyc(1, 0, 0, 0);
            for (int a = 1; a <= FP; a++) begin
                if (kind == 1 && a == FP) continue;
                for (int g = 1; g < gap; g++) cyc(1, ($urandom_range(0, 4) == 0), 0, $urandom);
                cyc(1, 1, a, $urandom);
                if (kind == 3 && $urandom_range(0, 7) == 0) rd_bank = ~rd_bank;
            end
            if (kind == 2) cyc(1, 1, $urandom_range(FP + 1, (1 << AW) - 1), $urandom);
            cyc(0, $urandom_range(0, 1), $urandom_range(1, FP), $urandom);
            for (int g = 0; g < gap; g++) cyc(0, 0, 0, 0);
        end

        // Counter wrap on the small instance.
        pix.vsync = 0; pix.buff_wr = 0;
        clear_stats();
        for (int f = 1; f <= 16; f++) begin
            cyc2(1, 0, 0);
            for (int a = 1; a <= FP2; a++) cyc2(1, 1, a);
            cyc2(0, 0, 0);
            cyc2(0, 0, 0);
            if (f == 15) chk("wrap_count_15", frame_count2, 15);
        end
        chk("wrap_count_0", frame_count2, 0);
        chk("wrap_done_pulses", done_pulses, 16);
        chk("wrap_done_valid", done_valid2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
